// File: rtl/fx2_pkg.sv
// Shared FX2 slave-FIFO definitions: pin addresses, header tag,
// EP6 transmit state encoding and the burst-length clamp.
package fx2_pkg;

  localparam logic [1:0] FX2_ADDR_EP2 = 2'b00;
  localparam logic [1:0] FX2_ADDR_EP6 = 2'b10;
  localparam logic [3:0] EP6_HDR_TAG  = 4'hA;

  typedef enum logic [2:0] {
    IDLE,
    SEL,
    HDR0,
    HDR1,
    DATA
  } ep6_state_e;

  function automatic logic [7:0] clamp_len(
    input logic [31:0] cnt,
    input logic [31:0] max_burst
  );
    logic [31:0] len;
    len = (cnt > max_burst) ? max_burst : cnt;
    return len[7:0];
  endfunction

endpackage

// File: rtl/fx2_ep6_transmitter_rr_arbiter_4.sv
// Four-way round-robin pick: first requester at or after ptr,
// wrapping past port 3 back to port 0.
module rr_arbiter_4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [1:0] grant_idx,
  output logic       any
);

  logic [1:0] idx0;
  logic [1:0] idx1;
  logic [1:0] idx2;
  logic [1:0] idx3;

  assign idx0 = ptr;
  assign idx1 = ptr + 2'd1;
  assign idx2 = ptr + 2'd2;
  assign idx3 = ptr + 2'd3;
  assign any  = |req;

  always_comb begin
    grant_idx = ptr;
    priority case (1'b1)
      req[idx0]: grant_idx = idx0;
      req[idx1]: grant_idx = idx1;
      req[idx2]: grant_idx = idx2;
      req[idx3]: grant_idx = idx3;
      default:   grant_idx = ptr;
    endcase
  end

endmodule

// File: rtl/fx2_ep6_transmitter.sv
// EP6 IN path: drains four tracking FIFOs round-robin and frames each
// burst as [A0|port][len][data] onto the shared FX2 slave-FIFO pins.
module fx2_ep6_transmitter
  import fx2_pkg::*;
#(
  parameter int MAX_BURST = 64,
  parameter int COUNT_W   = 11
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        ep6_port_datas,
  input  logic [4*COUNT_W-1:0] ep6_port_counts,
  output logic [3:0]         ep6_port_read,
  output logic               tx_request,
  input  logic               tx_grant,
  output logic [1:0]         usb_addr,
  output logic [7:0]         usb_data_in,
  output logic               usb_slwr,
  input  logic               usb_ep6_full
);

  ep6_state_e state;

  logic [1:0] rr_ptr;
  logic [1:0] port;
  logic [7:0] len;
  logic [7:0] remain;

  logic [3:0]         nonzero;
  logic [1:0]         arb_idx;
  logic               arb_any;
  logic [COUNT_W-1:0] sel_count;
  logic [7:0]         sel_len;
  logic [7:0]         head_byte;
  logic               in_pkt;
  logic               wr_ok;

  always_comb begin
    nonzero = '0;
    for (int p = 0; p < 4; p++) begin
      nonzero[p] = |ep6_port_counts[COUNT_W*p +: COUNT_W];
    end
  end

  rr_arbiter_4 u_arb (
    .req       (nonzero),
    .ptr       (rr_ptr),
    .grant_idx (arb_idx),
    .any       (arb_any)
  );

  always_comb begin
    sel_count = ep6_port_counts[0 +: COUNT_W];
    for (int p = 0; p < 4; p++) begin
      if (arb_idx == 2'(p)) begin
        sel_count = ep6_port_counts[COUNT_W*p +: COUNT_W];
      end
    end
  end

  assign sel_len = clamp_len(32'(sel_count), 32'(MAX_BURST));

  always_comb begin
    head_byte = ep6_port_datas[7:0];
    for (int p = 0; p < 4; p++) begin
      if (port == 2'(p)) begin
        head_byte = ep6_port_datas[8*p +: 8];
      end
    end
  end

  assign in_pkt   = (state == HDR0) || (state == HDR1) || (state == DATA);
  assign wr_ok    = tx_grant & ~usb_ep6_full & in_pkt;
  assign usb_slwr = ~wr_ok;

  // FWFT heads change only on a pop, so the mux holds through a stall
  always_comb begin
    usb_data_in = 8'h00;
    unique case (state)
      HDR0:    usb_data_in = {EP6_HDR_TAG, 2'b00, port};
      HDR1:    usb_data_in = len;
      DATA:    usb_data_in = head_byte;
      default: usb_data_in = 8'h00;
    endcase
  end

  always_comb begin
    ep6_port_read = '0;
    if (state == DATA && wr_ok) begin
      ep6_port_read[port] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      rr_ptr     <= 2'd0;
      port       <= 2'd0;
      len        <= 8'd0;
      remain     <= 8'd0;
      tx_request <= 1'b0;
      usb_addr   <= FX2_ADDR_EP2;
    end else begin
      unique case (state)
        IDLE: begin
          if (arb_any) state <= SEL;
        end
        SEL: begin
          if (arb_any) begin
            port       <= arb_idx;
            len        <= sel_len;
            remain     <= sel_len;
            tx_request <= 1'b1;
            usb_addr   <= FX2_ADDR_EP6;
            state      <= HDR0;
          end else begin
            state <= IDLE;
          end
        end
        HDR0: begin
          if (wr_ok) state <= HDR1;
        end
        HDR1: begin
          if (wr_ok) state <= DATA;
        end
        DATA: begin
          if (wr_ok) begin
            remain <= remain - 8'd1;
            if (remain == 8'd1) begin
              state      <= IDLE;
              tx_request <= 1'b0;
              usb_addr   <= FX2_ADDR_EP2;
              rr_ptr     <= port + 2'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fx2_ep6_transmitter.sv
// Bench for fx2_ep6_transmitter: FWFT FIFO models per port, a write
// logger on the FX2 side, and a packet-level round-robin reference.
module tb_fx2_ep6_transmitter;

  localparam int CW = 11;
  localparam int MB = 64;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [31:0]   datas;
  logic [4*CW-1:0] counts;
  logic [3:0]    rd;
  logic          txr;
  logic          grant = 1'b1;
  logic [1:0]    addr;
  logic [7:0]    din;
  logic          slwr;
  logic          full = 1'b0;

  always #5 clk = ~clk;

  fx2_ep6_transmitter #(.MAX_BURST(MB), .COUNT_W(CW)) dut (
    .clk             (clk),
    .reset           (reset),
    .ep6_port_datas  (datas),
    .ep6_port_counts (counts),
    .ep6_port_read   (rd),
    .tx_request      (txr),
    .tx_grant        (grant),
    .usb_addr        (addr),
    .usb_data_in     (din),
    .usb_slwr        (slwr),
    .usb_ep6_full    (full)
  );

  logic [7:0] mem [4][2048];
  int wr_cnt [4];
  int rd_cnt [4];
  int cyc = 0;

  logic [7:0] wlog [4096];
  int         wcyc [4096];
  logic       wok  [4096];
  int         wr_n = 0;

  int tests = 0;
  int fails = 0;
  int cur = 0;
  logic [7:0] exp_q [$];

  always_comb begin
    counts = '0;
    datas  = '0;
    for (int p = 0; p < 4; p++) begin
      counts[CW*p +: CW] = CW'(wr_cnt[p] - rd_cnt[p]);
      datas[8*p +: 8]    = mem[p][rd_cnt[p][10:0]];
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int p = 0; p < 4; p++) begin
      if (rd[p]) rd_cnt[p] <= rd_cnt[p] + 1;
    end
  end

  always @(negedge clk) begin
    if (reset && !slwr) begin
      wlog[wr_n] <= din;
      wcyc[wr_n] <= cyc;
      wok[wr_n]  <= txr && (addr == 2'b10);
      wr_n       <= wr_n + 1;
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input int p, input logic [7:0] b);
    mem[p][wr_cnt[p]] = b;
    wr_cnt[p]++;
  endtask

  task automatic add_pkt(input int p, input int start, input int n);
    exp_q.push_back(8'hA0 | 8'(p));
    exp_q.push_back(8'(n));
    for (int i = 0; i < n; i++) exp_q.push_back(mem[p][start+i]);
  endtask

  // Packet-level reference: serve non-empty ports in rr order from ptr
  task automatic model(input int ptr0);
    int rem [4];
    int pos [4];
    int ptr;
    int p;
    int n;
    ptr = ptr0;
    for (int i = 0; i < 4; i++) begin
      rem[i] = wr_cnt[i] - rd_cnt[i];
      pos[i] = rd_cnt[i];
    end
    while (rem[0] + rem[1] + rem[2] + rem[3] > 0) begin
      p = -1;
      for (int k = 0; k < 4; k++) begin
        if (p < 0 && rem[(ptr+k)%4] > 0) p = (ptr + k) % 4;
      end
      n = (rem[p] > MB) ? MB : rem[p];
      add_pkt(p, pos[p], n);
      pos[p] += n;
      rem[p] -= n;
      ptr = (p + 1) % 4;
    end
  endtask

  task automatic wait_wr(input int target, input int budget);
    int k;
    k = 0;
    while (wr_n < target && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    chk("wait_writes", (wr_n >= target) ? 1 : 0, 1);
  endtask

  task automatic chk_stream(input string tag);
    repeat (6) @(posedge clk);
    #1;
    chk({tag, " count"}, wr_n - cur, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (cur + i < wr_n) begin
        chk($sformatf("%s byte%0d", tag, i), int'(wlog[cur+i]), int'(exp_q[i]));
        chk($sformatf("%s req%0d", tag, i), int'(wok[cur+i]), 1);
      end
    end
    cur = wr_n;
    exp_q.delete();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    cur = wr_n;
  endtask

  initial begin
    int s0, s1, s2, s3, base, r0, rd2, tgt, k;

    repeat (3) @(posedge clk);
    #1;
    chk("rst read", int'(rd), 0);
    chk("rst txreq", int'(txr), 0);
    chk("rst addr", int'(addr), 0);
    chk("rst data", int'(din), 0);
    chk("rst slwr", int'(slwr), 1);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // ports 0,1,3 one byte each; refill 0 and 1 while 3 sends
    s0 = wr_cnt[0]; s1 = wr_cnt[1]; s3 = wr_cnt[3];
    push(0, 8'($urandom)); push(1, 8'($urandom)); push(3, 8'($urandom));
    add_pkt(0, s0, 1); add_pkt(1, s1, 1); add_pkt(3, s3, 1);
    wait_wr(cur + 7, 200);
    push(0, 8'($urandom)); push(1, 8'($urandom));
    add_pkt(0, s0 + 1, 1); add_pkt(1, s1 + 1, 1);
    wait_wr(cur + 15, 300);
    chk_stream("t3 rr");

    // port 2, three bytes, back-to-back writes
    s2 = wr_cnt[2]; r0 = rd_cnt[2];
    push(2, 8'h11); push(2, 8'h22); push(2, 8'h33);
    add_pkt(2, s2, 3);
    base = cur;
    wait_wr(cur + 5, 200);
    chk("t1 consecutive", wcyc[base+4] - wcyc[base], 4);
    chk_stream("t1 pkt");
    chk("t1 pops", rd_cnt[2] - r0, 3);

    // port 0, 200 bytes -> 64,64,64,8
    s0 = wr_cnt[0]; r0 = rd_cnt[0];
    for (int i = 0; i < 200; i++) push(0, 8'($urandom));
    add_pkt(0, s0, 64); add_pkt(0, s0 + 64, 64);
    add_pkt(0, s0 + 128, 64); add_pkt(0, s0 + 192, 8);
    wait_wr(cur + 208, 2000);
    chk_stream("t2 burst");
    chk("t2 pops", rd_cnt[0] - r0, 200);

    // full on the 2nd data byte for 4 cycles
    s3 = wr_cnt[3]; r0 = rd_cnt[3];
    for (int i = 0; i < 4; i++) push(3, 8'($urandom));
    add_pkt(3, s3, 4);
    base = cur;
    wait_wr(base + 3, 200);
    full = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t4 slwr", int'(slwr), 1);
      chk("t4 read", int'(rd), 0);
      chk("t4 data", int'(din), int'(mem[3][s3+1]));
    end
    @(posedge clk); #1;
    full = 1'b0;
    wait_wr(base + 6, 200);
    chk_stream("t4 full");
    chk("t4 pops", rd_cnt[3] - r0, 4);

    // grant dropped in HDR1 for 3 cycles
    s1 = wr_cnt[1];
    for (int i = 0; i < 5; i++) push(1, 8'($urandom));
    add_pkt(1, s1, 5);
    base = cur;
    wait_wr(base + 1, 200);
    grant = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5 slwr", int'(slwr), 1);
      chk("t5 txreq", int'(txr), 1);
      chk("t5 addr", int'(addr), 2);
      chk("t5 len", int'(din), 5);
    end
    @(posedge clk); #1;
    grant = 1'b1;
    wait_wr(base + 7, 200);
    chk_stream("t5 grant");

    // randomized rounds with random grant/full stalls
    for (int r = 0; r < 3; r++) begin
      do_reset();
      k = $urandom_range(0, 3);
      for (int p = 0; p < 4; p++) begin
        int n;
        n = $urandom_range(0, 150);
        if (p == k && n == 0) n = 1;
        for (int i = 0; i < n; i++) push(p, 8'($urandom));
      end
      model(0);
      tgt = cur + exp_q.size();
      k = 0;
      while (wr_n < tgt && k < 8000) begin
        @(posedge clk); #1;
        grant = ($urandom_range(0, 3) != 0);
        full  = ($urandom_range(0, 4) == 0);
        k++;
      end
      grant = 1'b1;
      full  = 1'b0;
      chk_stream($sformatf("rnd%0d", r));
      for (int p = 0; p < 4; p++) begin
        chk($sformatf("rnd%0d drain%0d", r, p), wr_cnt[p] - rd_cnt[p], 0);
      end
    end

    // reset mid-DATA, then restart from port 0
    do_reset();
    s1 = wr_cnt[1];
    push(1, 8'($urandom)); push(1, 8'($urandom));
    add_pkt(1, s1, 2);
    wait_wr(cur + 4, 200);
    chk_stream("t6 pre");
    for (int i = 0; i < 20; i++) push(2, 8'($urandom));
    wait_wr(cur + 5, 200);
    reset = 1'b0;
    #1;
    chk("t6 slwr", int'(slwr), 1);
    chk("t6 read", int'(rd), 0);
    chk("t6 txreq", int'(txr), 0);
    chk("t6 addr", int'(addr), 0);
    rd2 = rd_cnt[2];
    s0 = wr_cnt[0];
    push(0, 8'($urandom)); push(0, 8'($urandom)); push(0, 8'($urandom));
    push(3, 8'($urandom)); push(3, 8'($urandom));
    repeat (3) @(posedge clk);
    #1;
    chk("t6 nopop", rd_cnt[2], rd2);
    cur = wr_n;
    reset = 1'b1;
    model(0);
    chk("t6 first hdr", int'(exp_q[0]), 8'hA0);
    tgt = cur + exp_q.size();
    wait_wr(tgt, 600);
    chk_stream("t6 post");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
